// File: rtl/rng_xy_gen_pkg.sv
// Shared constants, FSM state type and range-mask helper for the rng_xy_gen block.
package rng_pkg;

    localparam logic [15:0] TAPS16         = 16'hB400;
    localparam logic [31:0] TAPS32         = 32'h8020_0003;
    localparam logic [15:0] DEFAULT_SEED16 = 16'hACE1;
    localparam logic [31:0] DEFAULT_SEED32 = 32'hACE1_ACE1;

    typedef enum logic [1:0] {
        GEN_X,
        GEN_Y,
        HOLD
    } state_t;

    // Smear the highest set bit downwards: all ones from the MSB of limit to bit 0.
    function automatic logic [31:0] mask_of(input logic [31:0] limit);
        logic [31:0] m;
        m = limit;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/rng_xy_gen_if.sv
// Output handshake bundle of rng_xy_gen: coordinate pair plus valid/ready.
interface rng_xy_gen_if #(
    parameter int CW = 8
);

    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] x;
    logic [CW-1:0] y;

    modport master (output out_valid, output x, output y, input out_ready);
    modport slave  (input out_valid, input x, input y, output out_ready);

endinterface

// File: rtl/rng_xy_gen_lfsr_core.sv
// Galois right-shift LFSR with synchronous reseed; a zero seed is swapped for the default.
module lfsr_core
    import rng_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] lfsr,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [WIDTH-1:0] TAPS  = (WIDTH == 32) ? WIDTH'(TAPS32) : WIDTH'(TAPS16);
    localparam logic [WIDTH-1:0] DSEED = (WIDTH == 32) ? WIDTH'(DEFAULT_SEED32) : WIDTH'(DEFAULT_SEED16);

    always_comb begin
        nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= DSEED;
        end else if (load) begin
            lfsr <= (seed == '0) ? DSEED : seed;
        end else if (step) begin
            lfsr <= nxt;
        end
    end

endmodule

// File: rtl/rng_xy_gen.sv
// Bias-free random (x, y) pair generator using mask-and-reject on an LFSR stream.
// Optional RNG_STATS_EN adds pair_cnt / reject_cnt statistics outputs.
module rng_xy_gen
    import rng_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic [CW-1:0]    x_limit,
    input  logic [CW-1:0]    y_limit,
    rng_xy_gen_if.master     bus
`ifdef RNG_STATS_EN
    ,
    output logic [15:0]      pair_cnt,
    output logic [15:0]      reject_cnt
`endif
);

    state_t           state;
    logic [CW-1:0]    lim_x;
    logic [CW-1:0]    lim_y;
    logic [CW-1:0]    lim_sel;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] cand_w;
    logic [WIDTH-1:0] lim_w;
    logic             step;
    logic             accept;
    logic             handshake;

    // The register can never legally be zero; the guard stops a corrupted state from stepping.
    assign step      = (state != HOLD) && (lfsr != '0);
    assign handshake = (state == HOLD) && bus.out_valid && bus.out_ready;

    lfsr_core #(.WIDTH(WIDTH)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .seed  (seed),
        .step  (step),
        .lfsr  (lfsr),
        .nxt   (nxt)
    );

    always_comb begin
        lim_sel = (state == GEN_Y) ? lim_y : lim_x;
        lim_w   = WIDTH'(lim_sel);
        cand_w  = nxt & WIDTH'(mask_of(32'(lim_sel)));
        accept  = (cand_w <= lim_w);
    end

    // Load overrides everything and abandons the pair in progress; x/y keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= GEN_X;
            bus.out_valid <= 1'b0;
            bus.x         <= '0;
            bus.y         <= '0;
            lim_x         <= '1;
            lim_y         <= '1;
        end else if (load) begin
            state         <= GEN_X;
            bus.out_valid <= 1'b0;
            lim_x         <= x_limit;
            lim_y         <= y_limit;
        end else begin
            case (state)
                GEN_X: begin
                    if (accept) begin
                        bus.x <= cand_w[CW-1:0];
                        state <= GEN_Y;
                    end
                end
                GEN_Y: begin
                    if (accept) begin
                        bus.y         <= cand_w[CW-1:0];
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        bus.out_valid <= 1'b0;
                        lim_x         <= x_limit;
                        lim_y         <= y_limit;
                        state         <= GEN_X;
                    end
                end
                default: state <= GEN_X;
            endcase
        end
    end

`ifdef RNG_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt   <= '0;
            reject_cnt <= '0;
        end else if (load) begin
            pair_cnt   <= '0;
            reject_cnt <= '0;
        end else begin
            if (handshake) begin
                pair_cnt <= pair_cnt + 16'd1;
            end
            if (step && !accept && (reject_cnt != 16'hFFFF)) begin
                reject_cnt <= reject_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rng_xy_gen.sv
// Self-checking bench for rng_xy_gen: pair-level reference model plus directed literal checks.
module tb_rng_xy_gen;

    localparam int WIDTH = 16;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] seed = '0;
    logic [CW-1:0]    x_limit = '1;
    logic [CW-1:0]    y_limit = '1;

    int tests = 0;
    int fails = 0;

    rng_xy_gen_if #(.CW(CW)) bus ();

`ifdef RNG_STATS_EN
    logic [15:0] pair_cnt;
    logic [15:0] reject_cnt;
`endif

    rng_xy_gen #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seed    (seed),
        .load    (load),
        .x_limit (x_limit),
        .y_limit (y_limit),
        .bus     (bus)
`ifdef RNG_STATS_EN
        ,
        .pair_cnt   (pair_cnt),
        .reject_cnt (reject_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole pairs drawn with plain arithmetic, then timed by draw count.
    int unsigned m_lfsr;
    int          m_lim_x, m_lim_y;
    bit          exp_valid;
    int          exp_x, exp_y, px, py, lat, wait_cnt, pend_rej;
    int          m_pairs, m_rej_done;

    function automatic int unsigned lfsr_next(input int unsigned v);
        return (v & 1) ? ((v >> 1) ^ 32'hB400) : (v >> 1);
    endfunction

    function automatic int mask_for(input int lim);
        int m;
        m = 0;
        while (m < lim) m = (m << 1) | 1;
        return m;
    endfunction

    task model_start();
        int c;
        int draws;
        exp_valid = 1'b0;
        wait_cnt  = 0;
        draws     = 0;
        do begin
            m_lfsr = lfsr_next(m_lfsr);
            c = int'(m_lfsr) & mask_for(m_lim_x);
            draws++;
        end while (c > m_lim_x);
        px = c;
        do begin
            m_lfsr = lfsr_next(m_lfsr);
            c = int'(m_lfsr) & mask_for(m_lim_y);
            draws++;
        end while (c > m_lim_y);
        py       = c;
        lat      = draws;
        pend_rej = draws - 2;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr     = 32'hACE1;
            m_lim_x    = 255;
            m_lim_y    = 255;
            m_pairs    = 0;
            m_rej_done = 0;
            model_start();
        end else if (load) begin
            m_lfsr     = (seed == '0) ? 32'hACE1 : int'(seed);
            m_lim_x    = int'(x_limit);
            m_lim_y    = int'(y_limit);
            m_pairs    = 0;
            m_rej_done = 0;
            model_start();
        end else if (exp_valid && bus.out_ready) begin
            m_pairs = (m_pairs + 1) & 16'hFFFF;
            m_lim_x = int'(x_limit);
            m_lim_y = int'(y_limit);
            model_start();
        end else if (!exp_valid) begin
            wait_cnt++;
            if (wait_cnt == lat) begin
                exp_valid  = 1'b1;
                exp_x      = px;
                exp_y      = py;
                m_rej_done = (m_rej_done + pend_rej > 65535) ? 65535 : m_rej_done + pend_rej;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check_output("model_valid", int'(bus.out_valid), int'(exp_valid));
            if (exp_valid) begin
                check_output("model_x", int'(bus.x), exp_x);
                check_output("model_y", int'(bus.y), exp_y);
`ifdef RNG_STATS_EN
                check_output("model_pair_cnt", int'(pair_cnt), m_pairs);
                check_output("model_reject_cnt", int'(reject_cnt), m_rej_done);
`endif
            end
        end
    end

    task automatic apply_load(input logic [WIDTH-1:0] s, input int lx, input int ly);
        @(negedge clk);
        seed    = s;
        x_limit = CW'(lx);
        y_limit = CW'(ly);
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) check_output({name, "_timeout"}, 0, 1);
    endtask

    task automatic take_pair(input string name, output int px_o, output int py_o);
        wait_valid(name);
        px_o = int'(bus.x);
        py_o = int'(bus.y);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    int ax[6], ay[6], bx[6], by[6];
    int hs, tx, ty;

    initial begin
        bus.out_ready = 1'b0;

        #12;
        check_output("reset_valid", int'(bus.out_valid), 0);
        check_output("reset_x", int'(bus.x), 0);
        check_output("reset_y", int'(bus.y), 0);
`ifdef RNG_STATS_EN
        check_output("reset_pair_cnt", int'(pair_cnt), 0);
        check_output("reset_reject_cnt", int'(reject_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        apply_load(16'h15B3, 255, 255);
        check_output("full_lat0_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        check_output("full_lat1_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        check_output("full_lat2_valid", int'(bus.out_valid), 1);
        check_output("full_x", int'(bus.x), 217);
        check_output("full_y", int'(bus.y), 108);
        x_limit = 8'd3;
        y_limit = 8'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("hold_valid", int'(bus.out_valid), 1);
            check_output("hold_x", int'(bus.x), 217);
            check_output("hold_y", int'(bus.y), 108);
        end

        apply_load(16'h15B3, 100, 100);
        check_output("lim100_lat0_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        check_output("lim100_lat1_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        check_output("lim100_lat2_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        check_output("lim100_lat3_valid", int'(bus.out_valid), 1);
        check_output("lim100_x", int'(bus.x), 89);
        check_output("lim100_y", int'(bus.y), 54);
        for (int i = 0; i < 4; i++) take_pair("lim100_seq", tx, ty);

        apply_load(16'h0000, 200, 50);
        for (int i = 0; i < 6; i++) take_pair("seed0", ax[i], ay[i]);
        apply_load(16'hACE1, 200, 50);
        for (int i = 0; i < 6; i++) take_pair("seedace1", bx[i], by[i]);
        for (int i = 0; i < 6; i++) begin
            check_output("seed0_x_vs_ace1", ax[i], bx[i]);
            check_output("seed0_y_vs_ace1", ay[i], by[i]);
        end
        check_output("seed0_not_stuck",
                     int'((ax[0] != ax[1]) || (ax[1] != ax[2]) || (ay[0] != ay[1])), 1);

        bus.out_ready = 1'b1;
        apply_load(16'h7777, 0, 0);
        hs = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) begin
                hs++;
                check_output("zero_x", int'(bus.x), 0);
                check_output("zero_y", int'(bus.y), 0);
            end
            @(negedge clk);
        end
        check_output("zero_handshakes_30cyc", hs, 10);
        bus.out_ready = 1'b0;

        apply_load(16'h1234, 150, 90);
        wait_valid("hold_load");
        @(negedge clk);
        bus.out_ready = 1'b1;
        seed = 16'h4321;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        bus.out_ready = 1'b0;
        check_output("load_in_hold_valid", int'(bus.out_valid), 0);
`ifdef RNG_STATS_EN
        check_output("load_in_hold_pair_cnt", int'(pair_cnt), 0);
`endif
        take_pair("after_load", tx, ty);

        for (int r = 0; r < 5; r++) begin
            apply_load(WIDTH'(16'h0101 * (r + 1)), 120, 200);
            wait_valid("reset_loop");
            #2;
            rst_n = 1'b0;
            #1;
            check_output("async_reset_valid", int'(bus.out_valid), 0);
            check_output("async_reset_x", int'(bus.x), 0);
            check_output("async_reset_y", int'(bus.y), 0);
            #97;
            @(negedge clk);
            rst_n = 1'b1;
        end

        apply_load(16'h2468, 100, 100);
        for (int i = 0; i < 1000; i++) begin
            wait_valid("stats");
            check_output("stats_x_range", int'(bus.x <= 8'd100), 1);
            check_output("stats_y_range", int'(bus.y <= 8'd100), 1);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
`ifdef RNG_STATS_EN
        check_output("stats_pair_cnt", int'(pair_cnt), 1000);
        check_output("stats_reject_cnt", int'(reject_cnt), m_rej_done);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
